// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B - B_in, LSB first, one bit per clock,
// with valid/ready handshakes on operand and result sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             B_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic bit_a;
    logic bit_b;
    logic d_bit;
    logic br_next;
    logic last_bit;

    // Full-subtractor slice on the current LSBs and the registered borrow.
    always_comb begin
        bit_a    = a_q[0];
        bit_b    = b_q[0];
        d_bit    = bit_a ^ bit_b ^ br_q;
        br_next  = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = B_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Diff      = diff_q;
    assign B_out     = bout_q;

endmodule
